// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: holds the PC, issues one read at a time to
// instruction memory, queues returned words in a 2-entry buffer and hands
// them to the decoder with their PC under a valid/ready handshake. A redirect
// flushes the buffer and restarts fetch from the new target.
module instruction_fetch_unit #(
   parameter int                    ADDR_WIDTH = 17,
   parameter int                    LEN        = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  chip_enabled,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_grant,
   input  logic                  mem_rvalid,
   input  logic [LEN-1:0]        mem_rdata,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [LEN-1:0]        instruction,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DISCARD
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic [1:0]            count;
   logic [LEN-1:0]        buf_word [2];
   logic [ADDR_WIDTH-1:0] buf_pc   [2];
   logic                  issue;
   logic                  push;
   logic                  pop;

   // Handshake decode and buffer-head outputs; redirect suppresses issue, push and pop.
   always_comb begin
      mem_req     = !rst && (state == S_IDLE) && chip_enabled && !redirect_valid
                    && (count != 2'd2);
      mem_addr    = pc;
      issue       = mem_req && mem_grant;
      push        = (state == S_WAIT) && mem_rvalid && !redirect_valid;
      instr_valid = (count != 2'd0) && chip_enabled;
      pop         = instr_valid && instr_ready && !redirect_valid;
      instruction = (count != 2'd0) ? buf_word[0] : '0;
      instr_pc    = (count != 2'd0) ? buf_pc[0]   : '0;
   end

   // Next state: a response arriving in WAIT or DISCARD always returns to IDLE;
   // a redirect without a response turns the outstanding read into a stale one.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (issue) state_next = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid)          state_next = S_IDLE;
            else if (redirect_valid) state_next = S_DISCARD;
         end
         S_DISCARD: begin
            if (mem_rvalid) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Control state: FSM, PC, request PC and buffer occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
         count  <= 2'd0;
      end else begin
         state <= state_next;
         if (redirect_valid) begin
            count <= 2'd0;
            pc    <= redirect_pc & ~ADDR_WIDTH'(3);
         end else begin
            if (issue) begin
               pc     <= pc + ADDR_WIDTH'(4);
               req_pc <= pc;
            end
            case ({push, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

   // Buffer storage: entry 0 is always the head, so a pop shifts entry 1 down
   // and a simultaneous push with one word held lands straight in the head.
   always_ff @(posedge clk) begin
      if (pop) begin
         if (push && (count == 2'd1)) begin
            buf_word[0] <= mem_rdata;
            buf_pc[0]   <= req_pc;
         end else begin
            buf_word[0] <= buf_word[1];
            buf_pc[0]   <= buf_pc[1];
         end
      end else if (push) begin
         if (count == 2'd0) begin
            buf_word[0] <= mem_rdata;
            buf_pc[0]   <= req_pc;
         end else begin
            buf_word[1] <= mem_rdata;
            buf_pc[1]   <= req_pc;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a latency-configurable memory model, a
// stream-level scoreboard (expected fetch address sequence and delivered
// {pc, word} order) and directed scenarios followed by a randomized run.
module tb_instruction_fetch_unit;
   localparam int AW = 17;
   localparam int LW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          chip_enabled;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_grant;
   logic          mem_rvalid;
   logic [LW-1:0] mem_rdata;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic [LW-1:0] instruction;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          instr_ready;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   instruction_fetch_unit #(.ADDR_WIDTH(AW), .LEN(LW), .RESET_PC('0)) dut (
      .clk            (clk),
      .rst            (rst),
      .chip_enabled   (chip_enabled),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_grant      (mem_grant),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready)
   );

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [LW-1:0] word_of(input logic [AW-1:0] a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // memory model: each granted address answers after lat_fix cycles (0 = random 1..4)
   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } rsp_t;
   rsp_t pend[$];
   rsp_t new_r;
   int   lat_fix   = 2;
   int   grant_cnt = 0;

   always @(negedge clk) begin
      if (mem_req && mem_grant) begin
         new_r.addr = mem_addr;
         new_r.due  = cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4)));
         pend.push_back(new_r);
         grant_cnt++;
      end
   end

   initial begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_of(pend[0].addr);
            void'(pend.pop_front());
         end
      end
   end

   // scoreboard: expected stream restarts at RESET_PC / redirect target and steps by 4
   typedef struct {
      logic [AW-1:0] pc;
      logic [LW-1:0] w;
   } exp_t;
   exp_t          exp_q[$];
   exp_t          e_pop;
   exp_t          e_new;
   logic [AW-1:0] fetch_pc;

   always @(negedge clk) begin
      if (!rst) begin
         if (!chip_enabled) chk("valid_while_disabled", 64'(instr_valid), 64'd0);
         if (exp_q.size() == 0) begin
            chk("empty_valid", 64'(instr_valid), 64'd0);
            chk("empty_instruction", 64'(instruction), 64'd0);
            chk("empty_instr_pc", 64'(instr_pc), 64'd0);
         end
      end
      if (rst) begin
         exp_q.delete();
         fetch_pc = '0;
      end else if (redirect_valid) begin
         chk("req_during_redirect", 64'(mem_req), 64'd0);
         exp_q.delete();
         fetch_pc = redirect_pc & ~AW'(3);
      end else begin
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_delivery", 64'(instr_valid), 64'd0);
            end else begin
               e_pop = exp_q.pop_front();
               chk("instr_pc", 64'(instr_pc), 64'(e_pop.pc));
               chk("instruction", 64'(instruction), 64'(e_pop.w));
            end
         end
         if (mem_req && mem_grant) begin
            chk("mem_addr", 64'(mem_addr), 64'(fetch_pc));
            e_new.pc = fetch_pc;
            e_new.w  = word_of(fetch_pc);
            exp_q.push_back(e_new);
            fetch_pc = fetch_pc + AW'(4);
            chk("no_push_into_full", 64'(exp_q.size() > 2), 64'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_instruction", 64'(instruction), 64'd0);
      chk("rst_instr_pc", 64'(instr_pc), 64'd0);
      tick();
      rst = 1'b0;
   endtask

   // returns in the cycle after the grant of address a (c = grant cycle, -1 on timeout)
   task automatic wait_grant(input logic [AW-1:0] a, output int c);
      c = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (mem_req && mem_grant && mem_addr == a) begin
            c = cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (c >= 0) tick();
      chk("grant_seen", 64'(c >= 0), 64'd1);
   endtask

   initial begin
      int c0, c1, c2, cs, g0;
      rst            = 1'b1;
      chip_enabled   = 1'b1;
      mem_grant      = 1'b1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // L=2, ready decoder: back-to-back stream at one word per 3 cycles
      lat_fix = 2;
      do_reset();
      cs = cyc;
      wait_grant(AW'(0), c0);
      chk("first_req_cycle", 64'(c0), 64'(cs));
      wait_grant(AW'(4), c1);
      chk("throughput_0_4", 64'(c1 - c0), 64'd3);
      wait_grant(AW'(8), c2);
      chk("throughput_4_8", 64'(c2 - c1), 64'd3);
      repeat (6) tick();

      // stalled decoder: two words fetched then issue stops
      instr_ready = 1'b0;
      do_reset();
      g0 = grant_cnt;
      repeat (20) tick();
      @(negedge clk);
      chk("grants_while_stalled", 64'(grant_cnt - g0), 64'd2);
      chk("req_when_full", 64'(mem_req), 64'd0);
      chk("valid_when_full", 64'(instr_valid), 64'd1);
      tick();
      instr_ready = 1'b1;
      wait_grant(AW'(8), c0);
      repeat (10) tick();

      // redirect while waiting on 0x10: stale response discarded
      lat_fix = 3;
      do_reset();
      wait_grant(AW'('h10), c0);
      redirect_valid = 1'b1;
      redirect_pc    = AW'('h103);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("discard_no_req", 64'(mem_req), 64'd0);
      chk("flush_valid", 64'(instr_valid), 64'd0);
      tick();
      wait_grant(AW'('h100), c1);
      chk("req_after_discard", 64'(c1), 64'(c0 + 4));
      repeat (10) tick();

      // redirect in the same cycle as the response for 0x10
      lat_fix = 2;
      do_reset();
      wait_grant(AW'('h10), c0);
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = AW'('h200);
      tick();
      redirect_valid = 1'b0;
      wait_grant(AW'('h200), c1);
      chk("req_after_redirect_rvalid", 64'(c1), 64'(c0 + 3));
      repeat (10) tick();

      // chip disabled with one word buffered and one outstanding
      lat_fix     = 4;
      instr_ready = 1'b0;
      do_reset();
      wait_grant(AW'(4), c0);
      chip_enabled = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("disabled_valid", 64'(instr_valid), 64'd0);
         chk("disabled_req", 64'(mem_req), 64'd0);
         tick();
      end
      chip_enabled = 1'b1;
      @(negedge clk);
      chk("reenabled_valid", 64'(instr_valid), 64'd1);
      chk("reenabled_no_req", 64'(mem_req), 64'd0);
      chk("reenabled_head_pc", 64'(instr_pc), 64'd0);
      tick();
      instr_ready = 1'b1;
      wait_grant(AW'(8), c1);
      repeat (10) tick();

      // pc wrap at the top of the address space, then reset mid-WAIT
      lat_fix     = 2;
      instr_ready = 1'b0;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = AW'('h1FFFF);
      tick();
      redirect_valid = 1'b0;
      wait_grant(AW'('h1FFFC), c0);
      wait_grant(AW'(0), c1);
      chk("wrap_next_req", 64'(c1), 64'(c0 + 3));
      rst          = 1'b1;
      chip_enabled = 1'b0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_mem_req", 64'(mem_req), 64'd0);
      chk("midrst_instruction", 64'(instruction), 64'd0);
      chk("midrst_instr_pc", 64'(instr_pc), 64'd0);
      repeat (4) tick();
      @(negedge clk);
      chk("stale_ignored", 64'(instruction), 64'd0);
      tick();
      chip_enabled = 1'b1;
      instr_ready  = 1'b1;
      wait_grant(AW'(0), c2);
      repeat (12) tick();

      // randomized traffic
      lat_fix = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         mem_grant      = ($urandom_range(0, 3) != 0);
         instr_ready    = ($urandom_range(0, 9) < 7);
         chip_enabled   = ($urandom_range(0, 9) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = AW'($urandom);
         tick();
      end
      redirect_valid = 1'b0;
      chip_enabled   = 1'b1;
      instr_ready    = 1'b1;
      mem_grant      = 1'b1;
      repeat (20) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end block that supplies instruction words to the DECODER. It holds the program counter and issues one-at-a-time read requests to instruction memory. Returned words go into a 2-entry buffer, and each word is presented downstream with its PC under a valid/ready handshake. A branch redirect flushes the buffer and restarts fetch from a new address.

## Interface
- ADDR_WIDTH, 17, byte-address width of instruction memory and PC
- LEN, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- chip_enabled  input  1  global enable; low freezes issue and pop
- mem_req  output  1  read request (combinational from state)
- mem_addr  output  ADDR_WIDTH  request address, equals pc
- mem_grant  input  1  memory accepts request this cycle (qualified by mem_req)
- mem_rvalid  input  1  read data valid
- mem_rdata  input  LEN  read data
- redirect_valid  input  1  branch/jump redirect
- redirect_pc  input  ADDR_WIDTH  redirect target; bits [1:0] forced to 0 on load
- instruction  output  LEN  buffer head word; 0 when buffer empty
- instr_pc  output  ADDR_WIDTH  PC of head word; 0 when empty
- instr_valid  output  1  buffer non-empty and chip_enabled
- instr_ready  input  1  decoder accepts head word

## Operation
- Single clock domain. There is one synchronous active-high reset, `rst`, sampled on the rising edge of `clk`.
- State machine with three states: IDLE, WAIT (one request outstanding), DISCARD (outstanding response belongs to a flushed stream).
- Buffer: 2-entry FIFO of {word, pc}, plus a count of 0..2.
- Request condition: mem_req = (state==IDLE) && chip_enabled && !redirect_valid && count<2. While mem_req is high, mem_addr = pc.
- mem_req && mem_grant: pc <= pc+4, modulo 2^ADDR_WIDTH (wraps to 0); request's pc latched as req_pc; state -> WAIT.
- WAIT && mem_rvalid: push {mem_rdata, req_pc}; state -> IDLE.
- DISCARD && mem_rvalid: data dropped; state -> IDLE.
- mem_rvalid in IDLE is ignored.
- Pop: instr_valid && instr_ready removes the head.
- Push and pop in the same cycle: count unchanged, order preserved.
- Push into a full buffer cannot happen, because issue requires count<2 and only one request may be outstanding. The bench asserts this never occurs.
- Redirect has priority over everything in its cycle:
  - buffer flushed (count <= 0) and pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00};
  - no request issued and no pop that cycle;
  - WAIT -> DISCARD, or WAIT -> IDLE if mem_rvalid is also high that cycle (response dropped);
  - IDLE stays IDLE; DISCARD stays DISCARD unless mem_rvalid, then -> IDLE.
- chip_enabled low:
  - no new request and instr_valid = 0, so no pop;
  - an outstanding response is still accepted and pushed or discarded;
  - redirect is still honoured.

## Timing
- Reset values:
  - pc = RESET_PC, state = IDLE, count = 0, req_pc = 0;
  - outputs: mem_req 0, instr_valid 0, instruction 0, instr_pc 0.
  - mem_req and mem_addr may assert in the first cycle after rst deasserts.
- rst asserted mid-operation: all state returns to reset values on the next edge. Any outstanding memory response is then ignored because the state is IDLE.
- Memory latency L ≥ 1 cycles from grant to rvalid. A word pushed on edge N is visible on instruction/instr_valid after edge N (registered buffer, no bypass).
- Steady-state throughput is one word per L+1 cycles: the next request issues the cycle after the push.
- Redirect seen at edge N:
  - first request to the new target can issue in cycle N+1 if IDLE;
  - if DISCARD, the request issues the cycle after the stale rvalid.
- Outputs instruction, instr_pc and instr_valid are functions of registers (and of chip_enabled for instr_valid) only. There is no combinational path from instr_ready or mem_rvalid.

## Test plan
- Reset, then memory with L=2 and always-ready decoder:
  - requests at addresses 0x0, 0x4, 0x8, one per 3 cycles;
  - decoder receives words W0, W1, W2 with instr_pc 0x0, 0x4, 0x8 in order.
- instr_ready held low:
  - exactly 2 words are fetched (0x0, 0x4), after which mem_req stays 0;
  - releasing instr_ready pops W0 then W1, and fetch resumes at 0x8.
- Redirect to 0x103 while in WAIT for address 0x10:
  - stale response discarded and buffer emptied;
  - next mem_addr = 0x100;
  - first delivered instr_pc = 0x100.
- Redirect in the same cycle as mem_rvalid for 0x10: data not pushed, state IDLE, next request at the redirect target one cycle later.
- chip_enabled low for 5 cycles while one word is buffered and one request is outstanding:
  - instr_valid stays 0 and no new mem_req;
  - the response still lands (count=2);
  - after re-enable both words pop in order.
- pc at 2^17−4: after its request is granted, pc wraps so the next mem_addr = 0x0. rst pulsed mid-WAIT returns all outputs to their reset values and the late rvalid is ignored.
